// File: rtl/game_outputs.sv
// game_outputs: CPU write port that serialises a 10-bit music/LED word to the
// external board over a 3-wire link (ser_clk, ser_data, ser_latch). A one-deep
// pending buffer plus a polled status word keep the CPU from stalling.
module game_outputs #(
  parameter int CLK_DIV = 4,
  parameter int FRAME_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  output logic [15:0] status,
  output logic        ser_clk,
  output logic        ser_data,
  output logic        ser_latch
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // clk cycles within a half-period / latch pulse
  logic [BIT_W-1:0]   bit_q, bit_d;        // index of the bit currently on the wire
  logic [FRAME_W-1:0] shift_q, shift_d;    // MSB is the bit currently on the wire
  logic [FRAME_W-1:0] pend_data_q, pend_data_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
  logic               ser_clk_q, ser_clk_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_latch_q, ser_latch_d;

  logic [FRAME_W-1:0] wr_frame_s;
  logic               launch_s;
  logic [FRAME_W-1:0] launch_data_s;
  logic               unused_wr_hi_s;

  assign wr_frame_s     = wr_data[FRAME_W-1:0];
  assign unused_wr_hi_s = ^wr_data[15:FRAME_W];

  // Next-state logic: frame sequencing, pending buffer and sticky overrun.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    pend_data_d   = pend_data_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q & ~rd_en;   // a read clears; a same-edge set below wins
    ser_clk_d     = ser_clk_q;
    ser_data_d    = ser_data_q;
    ser_latch_d   = ser_latch_q;
    launch_s      = 1'b0;
    launch_data_s = wr_frame_s;

    // Any write while a frame is in flight lands in the pending slot; if the
    // slot is already full the older word is lost and overrun is flagged.
    if (wr_en && (state_q != ST_IDLE)) begin
      overrun_d   = overrun_d | pending_q;
      pending_d   = 1'b1;
      pend_data_d = wr_frame_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          launch_s      = 1'b1;
          launch_data_s = wr_frame_s;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!ser_clk_q) begin
            ser_clk_d = 1'b1;                 // receiver samples on this rise
          end else if (bit_q == BIT_LAST) begin
            state_d     = ST_LATCH;
            ser_clk_d   = 1'b0;
            ser_data_d  = 1'b0;
            ser_latch_d = 1'b1;
          end else begin
            bit_d      = bit_q + BIT_W'(1);
            shift_d    = shift_q << 1;
            ser_clk_d  = 1'b0;
            ser_data_d = shift_q[FRAME_W-2];  // data only moves as ser_clk falls
          end
        end
      end

      ST_LATCH: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // End of latch pulse: a write on this very edge is the freshest word
          // and goes straight out; otherwise drain the pending slot.
          ser_latch_d = 1'b0;
          pending_d   = 1'b0;
          if (wr_en) begin
            launch_s      = 1'b1;
            launch_data_s = wr_frame_s;
          end else if (pending_q) begin
            launch_s      = 1'b1;
            launch_data_s = pend_data_q;
          end else begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            ser_clk_d  = 1'b0;
            ser_data_d = 1'b0;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        bit_d       = '0;
        pending_d   = 1'b0;
        ser_clk_d   = 1'b0;
        ser_data_d  = 1'b0;
        ser_latch_d = 1'b0;
      end
    endcase

    if (launch_s) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      bit_d       = '0;
      shift_d     = launch_data_s;
      ser_clk_d   = 1'b0;
      ser_data_d  = launch_data_s[FRAME_W-1];
      ser_latch_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pend_data_q <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pend_data_q <= pend_data_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_latch_q <= ser_latch_d;
    end
  end

  assign status    = {13'd0, overrun_q, pending_q, busy_q};
  assign ser_clk   = ser_clk_q;
  assign ser_data  = ser_data_q;
  assign ser_latch = ser_latch_q;

endmodule

// File: tb/tb_game_outputs.sv
// tb_game_outputs: directed test-plan steps followed by random traffic, every
// cycle compared against a frame-timing reference model.
module tb_game_outputs;

  localparam int D = 4;
  localparam int FP = 21 * D;   // frame period in clk cycles

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] status;
  logic        ser_clk;
  logic        ser_data;
  logic        ser_latch;

  game_outputs #(.CLK_DIV(D), .FRAME_W(10)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .status    (status),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_latch (ser_latch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: a frame is "active" with an offset into its 21*D period
  logic       m_active, m_pend, m_ov;
  int         m_off;
  logic [9:0] m_cur, m_pdata;

  // observation statistics
  int          cyc, busy_cnt, busy_rise, busy_falls, latch_rise, latch_cnt, nbits;
  logic [31:0] samp;
  logic        prev_clk, prev_busy, prev_latch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic set_ov;
    set_ov = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_off = 0; m_pend = 1'b0; m_ov = 1'b0; m_cur = '0; m_pdata = '0;
    end else begin
      if (!m_active) begin
        if (wr_en) begin
          m_active = 1'b1; m_off = 0; m_cur = wr_data[9:0];
        end
      end else begin
        m_off++;
        if (m_off == FP) begin
          m_off = 0;
          if (wr_en) begin
            set_ov = m_pend; m_cur = wr_data[9:0]; m_pend = 1'b0;
          end else if (m_pend) begin
            m_cur = m_pdata; m_pend = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end else if (wr_en) begin
          set_ov = m_pend; m_pend = 1'b1; m_pdata = wr_data[9:0];
        end
      end
      m_ov = (m_ov && !rd_en) || set_ov;
    end
  endtask

  function automatic logic [18:0] expect_out();
    logic c, d, l;
    int   bi;
    c = 1'b0; d = 1'b0; l = 1'b0;
    if (m_active) begin
      if (m_off < 20 * D) begin
        c  = (m_off % (2 * D)) >= D;
        bi = m_off / (2 * D);
        d  = m_cur[9 - bi];
      end else begin
        l = 1'b1;
      end
    end
    return {13'd0, m_ov, m_pend, m_active, c, d, l};
  endfunction

  task automatic clear_stats();
    busy_cnt = 0; busy_falls = 0; busy_rise = -1; latch_rise = -1; latch_cnt = 0;
    nbits = 0; samp = '0;
  endtask

  // one clock: DUT and model see the same inputs at the edge, outputs compared 1ns later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("outputs", {13'd0, status, ser_clk, ser_data, ser_latch}, {13'd0, expect_out()});
    if (status[0]) busy_cnt++;
    if (status[0] && !prev_busy) busy_rise = cyc;
    if (!status[0] && prev_busy) busy_falls++;
    if (ser_latch) latch_cnt++;
    if (ser_latch && !prev_latch) latch_rise = cyc;
    if (ser_clk && !prev_clk) begin
      samp = {samp[30:0], ser_data};
      nbits++;
    end
    prev_clk = ser_clk; prev_busy = status[0]; prev_latch = ser_latch;
  endtask

  task automatic write(input logic [15:0] d, input logic rd);
    wr_en = 1'b1; wr_data = d; rd_en = rd;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    cyc = 0; prev_clk = 1'b0; prev_busy = 1'b0; prev_latch = 1'b0;
    m_active = 1'b0; m_off = 0; m_pend = 1'b0; m_ov = 1'b0; m_cur = '0; m_pdata = '0;
    clear_stats();

    // reset held two edges, then quiet
    idle(2);
    check("reset_status", {16'd0, status}, 32'd0);
    check("reset_ser", {29'd0, ser_clk, ser_data, ser_latch}, 32'd0);
    rst_n = 1'b1;
    clear_stats();
    idle(50);
    check("quiet_busy_cnt", busy_cnt, 0);

    // single frame 0x155
    clear_stats();
    write(16'h0155, 1'b0);
    idle(FP + 20);
    check("single_bits", {22'd0, samp[9:0]}, 32'h155);
    check("single_nbits", nbits, 10);
    check("single_latch_off", latch_rise - busy_rise, 80);
    check("single_latch_len", latch_cnt, D);
    check("single_busy_len", busy_cnt, FP);
    check("single_status_end", {16'd0, status}, 32'd0);

    // upper bits ignored
    clear_stats();
    write(16'hFC00, 1'b0);
    idle(FP + 10);
    check("upper_bits", {22'd0, samp[9:0]}, 32'h0);
    check("upper_nbits", nbits, 10);
    check("upper_latch_len", latch_cnt, D);
    check("upper_status_end", {16'd0, status}, 32'd0);

    // back-to-back via the pending slot
    clear_stats();
    write(16'h03FF, 1'b0);
    idle(19);
    write(16'h0001, 1'b0);
    check("b2b_status", {16'd0, status}, 32'h3);
    idle(2 * FP);
    check("b2b_bits", {12'd0, samp[19:0]}, {12'd0, 10'h3FF, 10'h001});
    check("b2b_busy_len", busy_cnt, 2 * FP);
    check("b2b_busy_falls", busy_falls, 1);
    check("b2b_latch_len", latch_cnt, 2 * D);

    // overrun
    clear_stats();
    write(16'h0000, 1'b0);
    idle(4);
    write(16'h0001, 1'b0);
    idle(4);
    write(16'h0002, 1'b0);
    idle(4);
    write(16'h0004, 1'b0);
    check("ovr_status", {16'd0, status}, 32'h7);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("ovr_cleared", {16'd0, status}, 32'h3);
    idle(FP);                     // second frame (0x004) now in flight
    write(16'h0010, 1'b0);        // fills pending
    idle(3);
    write(16'h0020, 1'b1);        // overwrite and read on the same edge
    check("ovr_set_wins", {16'd0, status}, 32'h7);
    idle(2 * FP);
    check("ovr_second_frame", {22'd0, samp[19:10]}, 32'h004);
    check("ovr_third_frame", {22'd0, samp[9:0]}, 32'h020);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    idle(5);
    check("ovr_final", {16'd0, status}, 32'd0);

    // reset in the middle of the 5th bit with pending full
    clear_stats();
    write(16'h0155, 1'b0);
    idle(10);
    write(16'h0002, 1'b0);
    idle(24);
    check("midrst_pre", {16'd0, status}, 32'h3);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("midrst_status", {16'd0, status}, 32'd0);
    check("midrst_ser", {29'd0, ser_clk, ser_data, ser_latch}, 32'd0);
    clear_stats();
    idle(2 * FP);
    check("midrst_no_frame", busy_cnt + nbits + latch_cnt, 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      wr_en   = ($urandom_range(0, 29) == 0);
      wr_data = 16'($urandom);
      rd_en   = ($urandom_range(0, 19) == 0);
      rst_n   = ($urandom_range(0, 999) != 0);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
    idle(3 * FP);
    check("final_idle", {31'd0, status[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_outputs.md
Name: game_outputs

Overview:
- CPU-facing output port. It is the write-side counterpart of the game input register.
- The CPU writes a 16-bit word. The block serialises the low 10 bits (music[4:0] in bits 9..5, controller feedback/LED[4:0] in bits 4..0, the same packing as the input word) to the external music/controller board.
- The serial link is 3-wire: ser_clk, ser_data, ser_latch.
- A one-deep pending buffer and a status word let CPU software poll instead of stalling.

Parameters:
- CLK_DIV, 4: clk cycles per ser_clk half-period. Must be >= 1.
- FRAME_W, 10: bits per serial frame, taken from wr_data[FRAME_W-1:0].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_en  input  1  one-cycle write strobe from the CPU.
- wr_data  input  16  write data; bits 15..FRAME_W ignored.
- rd_en  input  1  status-read strobe; clears overrun.
- status  output  16  {13'b0, overrun, pending, busy}.
- ser_clk  output  1  serial clock to the board; idle low.
- ser_data  output  1  serial data, MSB first; idle low.
- ser_latch  output  1  frame-latch pulse; idle low.

Behaviour:
- Reset (reset==0 at a rising edge):
  - Next edge: state=IDLE; status=0; ser_clk=0, ser_data=0, ser_latch=0.
  - Shift and pending registers cleared.
  - Applies mid-frame: the frame is aborted and pending is dropped.
- States and transitions:
  - IDLE -> SHIFT on wr_en.
  - SHIFT -> LATCH after FRAME_W bits.
  - LATCH -> SHIFT if pending, else LATCH -> IDLE.
- Write in IDLE at edge k:
  - Edge k+1: busy=1, ser_data=wr_data[9], ser_clk=0.
- Per bit (CLK_DIV*2 cycles):
  - ser_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - ser_data changes only on the cycle ser_clk goes low; the receiver samples on ser_clk rising.
- After the 10th high phase, edge k+1+20*CLK_DIV:
  - ser_clk=0, ser_data=0, ser_latch=1.
  - ser_latch stays high for exactly CLK_DIV cycles.
- Edge k+1+21*CLK_DIV:
  - ser_latch=0.
  - If pending==0: busy=0 and state IDLE.
  - If pending==1: the next frame's first bit starts on this same edge, busy stays 1, pending clears.
- Write while busy, pending empty: wr_data[9:0] stored; pending=1.
- Write while busy, pending full: pending data overwritten with the newest word; overrun=1 (sticky).
- Write on the same edge the LATCH phase ends:
  - If pending empty: the write becomes the next frame directly; busy stays 1; no gap.
  - If pending full: treated as overwrite plus overrun.
- overrun clears on rd_en. If rd_en and an overrun-causing write occur on the same edge, set wins (overrun=1).
- status is registered and reflects state after the edge; a read the same cycle as a write sees the pre-write status.
- Frame period is 21*CLK_DIV cycles (84 at default).
- Frame word is wr_data[9:0], transmitted 9 down to 0.

Test Plan:
- Reset: hold reset=0 for 2 edges -> status=0, ser_clk/ser_data/ser_latch=0. Release; with no writes for 50 cycles all outputs stay 0.
- Single frame: wr_data=16'h0155 (music=01010, ctl=10101), one-cycle wr_en.
  - Bits sampled on ser_clk rising = 0101010101.
  - ser_latch high 4 cycles starting 80 cycles after busy rises.
  - busy high exactly 84 cycles, then status=0.
- Upper bits ignored: wr_data=16'hFC00 -> all 10 sampled bits 0, latch still pulses, status returns to 0.
- Pending/back-to-back: write 16'h03FF, then write 16'h0001 20 cycles later.
  - status=16'h0003 after the second write.
  - Second frame (0000000001) starts on the edge latch falls; busy never drops; total busy 168 cycles.
- Overrun: three writes while busy (16'h0001, 16'h0002, 16'h0004).
  - status=16'h0007.
  - Second frame transmits 0000000100.
  - rd_en pulse -> overrun=0.
  - rd_en on the same edge as a 4th overrun write -> overrun stays 1.
- Reset mid-frame: reset=0 during the 5th bit with pending=1 -> next edge all outputs 0, status=0; no further frame after release.
